// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for the programmable-range up/down counter.
// The master drives the count controls; the slave (the counter) returns count and event flags.
interface updown_counter_mod_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_down;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             unf;
    logic             load_err;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, up_down, step, load, load_val,
        input  count, ovf, unf, load_err, at_max, at_min
    );

    modport slave (
        input  en, up_down, step, load, load_val,
        output count, ovf, unf, load_err, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Programmable-range up/down counter with load, variable step, wrap/saturate
// behaviour and registered overflow/underflow/load-clamp event pulses.
module updown_counter_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_counter_mod_if.slave  bus
);
    // One extra bit so that count + step and the wrap offset never truncate,
    // which keeps ovf/unf correct when MAX_VAL is the full WIDTH range.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + 1'b1;
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic             ovf_q;
    logic             unf_q;
    logic             load_err_q;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   s_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   up_next;
    logic [WIDTH:0]   down_next;
    logic [WIDTH:0]   load_next;
    logic             up_over;
    logic             down_under;
    logic             load_over;

    always_comb begin
        count_ext  = {1'b0, count_q};
        step_ext   = {1'b0, bus.step};
        load_ext   = {1'b0, bus.load_val};

        s_eff      = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        sum        = count_ext + s_eff;

        up_over    = (sum > MAX_EXT);
        if (!up_over)
            up_next = sum;
        else if (SATURATE != 0)
            up_next = MAX_EXT;
        else
            up_next = sum - MOD_EXT;

        down_under = (s_eff > count_ext);
        if (!down_under)
            down_next = count_ext - s_eff;
        else if (SATURATE != 0)
            down_next = '0;
        else
            down_next = count_ext + MOD_EXT - s_eff;

        load_over  = (load_ext > MAX_EXT);
        load_next  = load_over ? MAX_EXT : load_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            count_q    <= load_next[WIDTH-1:0];
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            load_err_q <= load_over;
        end else if (bus.en) begin
            load_err_q <= 1'b0;
            if (bus.up_down) begin
                count_q <= up_next[WIDTH-1:0];
                ovf_q   <= up_over;
                unf_q   <= 1'b0;
            end else begin
                count_q <= down_next[WIDTH-1:0];
                ovf_q   <= 1'b0;
                unf_q   <= down_under;
            end
        end else begin
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.load_err = load_err_q;
    assign bus.at_max   = (count_q == MAX_W);
    assign bus.at_min   = (count_q == '0);
endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: three counter configurations share one stimulus stream; an
// integer reference model queues expected results and a monitor checks each cycle.
module tb_updown_counter_mod;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    updown_counter_mod_if #(.WIDTH(4)) if0 ();
    updown_counter_mod_if #(.WIDTH(4)) if1 ();
    updown_counter_mod_if #(.WIDTH(8)) if2 ();

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(0)) dut_wrap9 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1)) dut_sat9 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    updown_counter_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) dut_wrap255 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
        bit le;
    } exp_t;

    exp_t q[3][$];
    int   m_cnt[3];
    int   cfg_max[3]  = '{9, 9, 255};
    int   cfg_sat[3]  = '{0, 1, 0};
    int   cfg_mask[3] = '{15, 15, 255};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: behaviour expressed directly in integers from the range rules.
    function automatic exp_t model(input int i, input bit rst, input bit ld, input int lv8,
                                   input bit en, input bit ud, input int st8);
        exp_t e;
        int   mx, lv, s, t;
        mx = cfg_max[i];
        lv = lv8 & cfg_mask[i];
        s  = st8 & cfg_mask[i];
        if (s > mx) s = mx;
        e.ovf = 0; e.unf = 0; e.le = 0;
        if (rst) begin
            m_cnt[i] = 0;
        end else if (ld) begin
            e.le     = (lv > mx);
            m_cnt[i] = (lv > mx) ? mx : lv;
        end else if (en) begin
            if (ud) begin
                t = m_cnt[i] + s;
                if (t > mx) begin
                    e.ovf    = 1;
                    m_cnt[i] = cfg_sat[i] ? mx : t - (mx + 1);
                end else m_cnt[i] = t;
            end else begin
                if (s <= m_cnt[i]) m_cnt[i] = m_cnt[i] - s;
                else begin
                    e.unf    = 1;
                    m_cnt[i] = cfg_sat[i] ? 0 : m_cnt[i] + (mx + 1) - s;
                end
            end
        end
        e.cnt = m_cnt[i];
        return e;
    endfunction

    task automatic apply(input bit rst, input bit ld, input int lv8,
                         input bit en, input bit ud, input int st8);
        @(negedge clk);
        reset = rst;
        if0.load = ld; if1.load = ld; if2.load = ld;
        if0.en = en;   if1.en = en;   if2.en = en;
        if0.up_down = ud; if1.up_down = ud; if2.up_down = ud;
        if0.load_val = 4'(lv8); if1.load_val = 4'(lv8); if2.load_val = 8'(lv8);
        if0.step = 4'(st8);     if1.step = 4'(st8);     if2.step = 8'(st8);
        for (int i = 0; i < 3; i++) q[i].push_back(model(i, rst, ld, lv8, en, ud, st8));
    endtask

    task automatic check_dut(input int i, input int c, input bit o, input bit u,
                             input bit le, input bit amax, input bit amin);
        exp_t e;
        string p;
        if (q[i].size() == 0) return;
        e = q[i].pop_front();
        p = $sformatf("dut%0d", i);
        check({p, ".count"},    c,    e.cnt);
        check({p, ".ovf"},      o,    e.ovf);
        check({p, ".unf"},      u,    e.unf);
        check({p, ".load_err"}, le,   e.le);
        check({p, ".at_max"},   amax, (e.cnt == cfg_max[i]));
        check({p, ".at_min"},   amin, (e.cnt == 0));
    endtask

    always begin
        @(posedge clk);
        #1;
        check_dut(0, int'(if0.count), if0.ovf, if0.unf, if0.load_err, if0.at_max, if0.at_min);
        check_dut(1, int'(if1.count), if1.ovf, if1.unf, if1.load_err, if1.at_max, if1.at_min);
        check_dut(2, int'(if2.count), if2.ovf, if2.unf, if2.load_err, if2.at_max, if2.at_min);
    end

    initial begin
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 1, 1, 1);
        // wrap-9 count up through the boundary
        repeat (10) apply(0, 0, 0, 1, 1, 1);
        // load then down-step past zero
        apply(0, 1, 2, 0, 0, 0);
        repeat (2) apply(0, 0, 0, 1, 0, 3);
        // saturate at the top, then clamp step 15 downward
        apply(0, 1, 8, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 1, 1, 3);
        repeat (2) apply(0, 0, 0, 1, 0, 15);
        // out-of-range load, load beats enable
        apply(0, 1, 12, 0, 0, 0);
        apply(0, 1, 5, 1, 1, 9);
        apply(0, 0, 0, 0, 1, 9);
        // full-range wrap
        apply(0, 1, 250, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 10);
        apply(0, 0, 0, 1, 0, 5);
        // reset coincident with load and enable
        repeat (3) apply(0, 0, 0, 1, 1, 2);
        apply(1, 1, 7, 1, 1, 2);
        repeat (2) apply(0, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 1, 0, 0);

        for (int n = 0; n < 500; n++) begin
            bit r, l, e, d;
            int lv, st;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            lv = $urandom_range(0, 255);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
            apply(r, l, lv, e, d, st);
        end

        apply(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) check($sformatf("drain%0d", i), q[i].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised successor to the team's 4-bit up/down counter. It is a programmable-range up/down counter that adds these features:
- clock enable
- parallel load
- variable step size
- selectable wrap or saturate mode
- registered overflow/underflow event pulses

It is used wherever datapath and control logic need a bounded counter: BCD/modulo-N counting, credit tracking and address stepping.

Parameters:
WIDTH, 8, counter width in bits (>= 2)
MAX_VAL, 2**WIDTH-1, inclusive upper bound of count; legal range 1..2**WIDTH-1; count range is 0..MAX_VAL
SATURATE, 0, 0 = wrap modulo (MAX_VAL+1); 1 = clamp at 0 / MAX_VAL

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; count changes only when high (load excepted)
up_down  input  1  1 = count up, 0 = count down
step  input  WIDTH  increment/decrement magnitude, sampled when en=1
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count, registered
ovf  output  1  one-cycle pulse: up-count exceeded MAX_VAL (wrapped or clamped)
unf  output  1  one-cycle pulse: down-count went below 0 (wrapped or clamped)
load_err  output  1  one-cycle pulse: load_val > MAX_VAL was clamped
at_max  output  1  count == MAX_VAL (decoded from register, same cycle)
at_min  output  1  count == 0

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high on the clk/reset ports; there is no asynchronous path.
- Reset values: count=0, ovf=0, unf=0, load_err=0. Consequently at_min=1 and at_max=0 after reset.
- Priority per rising edge: reset > load > en > hold.
- Pulse outputs: ovf, unf and load_err are registered. They are high for exactly the cycle after the causing edge and return to 0 on the next edge unless re-triggered.
- Load:
  - count <= min(load_val, MAX_VAL).
  - load_err=1 iff load_val > MAX_VAL.
  - ovf=0 and unf=0.
  - en, up_down and step are ignored that cycle.
- Effective step: s = min(step, MAX_VAL). Internal arithmetic is WIDTH+1 bits, so there is no intermediate truncation.
- Up count (en=1, up_down=1):
  - If count + s <= MAX_VAL: count <= count + s, ovf=0.
  - Otherwise ovf=1.
  - Wrap mode: count <= count + s - (MAX_VAL+1).
  - Saturate mode: count <= MAX_VAL.
- Down count (en=1, up_down=0):
  - If s <= count: count <= count - s, unf=0.
  - Otherwise unf=1.
  - Wrap mode: count <= count + (MAX_VAL+1) - s.
  - Saturate mode: count <= 0.
- Saturate mode at the bound: a request that cannot move the count still pulses ovf/unf, e.g. up at MAX_VAL with s>0. The pulse repeats every cycle the request persists.
- step=0 with en=1: count holds; ovf, unf and load_err are all 0.
- en=0 and load=0: count holds; all pulses 0.
- Latency: one cycle from input sample to count/pulse update. at_max/at_min follow count combinationally.
- Reset asserted mid-sequence (including coincident with load or en) wins. No pending event survives.
- MAX_VAL = 2**WIDTH-1 must still produce correct ovf/unf; hence the WIDTH+1-bit comparison.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0.
   - Reset, then en=1, up_down=1, step=1 for 10 cycles -> count 1..9 then 0.
   - ovf high exactly on the cycle count shows 0; at_max high while count=9.
2. Same config, load 2 then down with step=3 -> count 2 -> 9 (2+10-3) with unf pulse.
   - Next cycle count=6, unf=0.
3. WIDTH=4, MAX_VAL=9, SATURATE=1.
   - Load 8, up step=3 -> count 9, ovf=1.
   - Hold request 2 more cycles -> count stays 9, ovf high each cycle.
   - Down step=15 (s=9) -> count 0, unf=0; repeat -> count 0, unf=1.
4. Load 12 with MAX_VAL=9 -> count=9, load_err=1 for one cycle.
   - load=1 and en=1 in the same cycle -> load wins, no ovf/unf.
5. WIDTH=8, MAX_VAL=255, wrap mode.
   - Load 250, up step=10 -> count 4, ovf=1.
   - Down step=5 -> count 255, unf=1.
6. Mid-count reset: with en=1 counting, assert reset together with load=1, load_val=7 -> count=0 and all pulses 0 next cycle.
   - en=1, step=0 afterwards -> count holds at 0, no pulses.
